// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl
//   Turns two raw push-buttons into the 4-bit duty code for the PWM stage.
//   Each button is synchronised, debounced and auto-repeated. The resulting
//   step requests drive a saturating up/down target. The target is copied to
//   the PWM-facing code only on the PWM period-wrap strobe, so a PWM period
//   never sees a mid-period duty change.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   btn_up       : raw asynchronous increment button, active-high
//   btn_dn       : raw asynchronous decrement button, active-high
//   frame_sync   : one-cycle strobe from the PWM stage at counter wrap
//   sw[3:0]      : duty code presented to the PWM stage
//   duty_pending : target differs from the presented code

// pwm_btn_chan
//   One button channel: 2-flop synchroniser, debouncer, press/auto-repeat
//   step generator.
//
// Ports
//   clk, rst : as above
//   btn_i    : raw button level
//   step_o   : one-cycle step request (press or repeat)
module pwm_btn_chan #(
  parameter int DB_CNT    = 50000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic step_o
);
  localparam int DBW = $clog2(DB_CNT + 1);
  localparam int HW  = $clog2(RPT_DELAY + 1);

  // Counter value in the last cycle before it would hit DB_CNT.
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CNT - 1);
  localparam logic [HW-1:0]  RPT_MATCH  = HW'(RPT_DELAY);
  // Reloading to this value makes the hold count revisit RPT_MATCH exactly
  // RPT_RATE cycles later, so repeats continue for as long as the button
  // stays down without the counter ever overflowing.
  localparam logic [HW-1:0]  RPT_RELOAD = HW'(RPT_DELAY - RPT_RATE + 1);

  logic           s1_q, s2_q;
  logic           db_q, db_d;
  logic           db_prev_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           press, rpt;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (s2_q != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = s2_q;
      else                     db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  // Hold count is 0 on the press cycle (db was low the cycle before).
  always_comb begin
    hold_d = '0;
    if (db_q) hold_d = (hold_q == RPT_MATCH) ? RPT_RELOAD : hold_q + HW'(1);
  end

  assign press  = db_q & ~db_prev_q;
  assign rpt    = db_q & (hold_q == RPT_MATCH);
  assign step_o = press | rpt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
    end
  end
endmodule

module pwm_duty_ctrl #(
  parameter int DB_CNT    = 50000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       frame_sync,
  output logic [3:0] sw,
  output logic       duty_pending
);
  localparam int NUM_BTN = 2;  // lane 0 = up, lane 1 = down

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] step;
  logic [3:0]         tgt_q, tgt_d;
  logic [3:0]         sw_q, sw_d;

  assign btn_raw = {btn_dn, btn_up};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    pwm_btn_chan #(
      .DB_CNT    (DB_CNT),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[gi]),
      .step_o (step[gi])
    );
  end

  // Saturating up/down; simultaneous up and down cancel.
  always_comb begin
    tgt_d = tgt_q;
    unique case (step)
      2'b01:   if (tgt_q != 4'hF) tgt_d = tgt_q + 4'd1;
      2'b10:   if (tgt_q != 4'h0) tgt_d = tgt_q - 4'd1;
      default: tgt_d = tgt_q;
    endcase
  end

  // Takes the pre-step target, so a step landing on the strobe waits a frame.
  assign sw_d = frame_sync ? tgt_q : sw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= 4'h0;
      sw_q  <= 4'h0;
    end else begin
      tgt_q <= tgt_d;
      sw_q  <= sw_d;
    end
  end

  assign sw           = sw_q;
  assign duty_pending = (tgt_q != sw_q);
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with DB_CNT=4, RPT_DELAY=20, RPT_RATE=5
// and frame_sync every 8 cycles. Inputs change and outputs are sampled 1 ns
// after the rising edge. After a button is raised, its debounced step lands
// on the 7th following edge.
module tb_pwm_duty_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] sw;
  logic       duty_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;

  pwm_duty_ctrl #(
    .DB_CNT    (4),
    .RPT_DELAY (20),
    .RPT_RATE  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_dn       (btn_dn),
    .frame_sync   (frame_sync),
    .sw           (sw),
    .duty_pending (duty_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // frame_sync is high during every cycle in which ph == 0.
  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
    frame_sync = (ph == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until one frame_sync edge has been taken.
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      seen = frame_sync;
      tick();
    end
    if (!seen) chk("fs_timeout", 0, 1);
  endtask

  // Short press (8 cycles), then enough idle for the release to debounce.
  task automatic tap(input bit up);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    ticks(8);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    ticks(12);
  endtask

  initial begin
    // Reset with buttons toggling
    rst = 1'b1; btn_up = 1'b1; btn_dn = 1'b0;
    tick();
    btn_up = 1'b0; btn_dn = 1'b1;
    tick();
    rst = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
    chk("rst_sw",  sw, 0);
    chk("rst_tgt", dut.tgt_q, 0);
    chk("rst_pend", duty_pending, 0);
    ticks(12);
    chk("idle_tgt",  dut.tgt_q, 0);
    chk("idle_pend", duty_pending, 0);

    // Bounce: 3 high, 2 low, then 10 steady high
    btn_up = 1'b1; ticks(3);
    btn_up = 1'b0; ticks(2);
    btn_up = 1'b1; ticks(6);
    chk("bnc_pre_tgt",  dut.tgt_q, 0);
    chk("bnc_pre_pend", duty_pending, 0);
    tick();
    chk("bnc_tgt",  dut.tgt_q, 1);
    chk("bnc_pend", duty_pending, 1);
    ticks(3);
    btn_up = 1'b0;
    wait_fs();
    chk("bnc_sw",     sw, 1);
    chk("bnc_pend0",  duty_pending, 0);
    ticks(30);
    chk("bnc_final",  dut.tgt_q, 1);

    // Climb to 13, then hold up for 120 cycles
    for (int i = 0; i < 12; i++) tap(1'b1);
    chk("climb13", dut.tgt_q, 13);
    btn_up = 1'b1;
    ticks(6);  chk("up_t6",   dut.tgt_q, 13);
    ticks(1);  chk("up_t7",   dut.tgt_q, 14);
    ticks(19); chk("up_t26",  dut.tgt_q, 14);
    ticks(1);  chk("up_t27",  dut.tgt_q, 15);
    ticks(6);  chk("up_t33",  dut.tgt_q, 15);
    ticks(87); chk("up_t120", dut.tgt_q, 15);
    btn_up = 1'b0;
    ticks(12);
    wait_fs();
    chk("up_sw15", sw, 15);

    // Hold down from 15: press + repeats at 27,32,...,87 -> 1
    btn_dn = 1'b1;
    ticks(84);
    btn_dn = 1'b0;
    ticks(16);
    chk("dn_to1", dut.tgt_q, 1);
    // Hold down from 1: reaches 0 and stays there through repeats
    btn_dn = 1'b1;
    ticks(6);  chk("dn1_t6",  dut.tgt_q, 1);
    ticks(1);  chk("dn1_t7",  dut.tgt_q, 0);
    ticks(53); chk("dn1_t60", dut.tgt_q, 0);
    btn_dn = 1'b0;
    ticks(12);

    // Simultaneous press from 7
    for (int i = 0; i < 7; i++) tap(1'b1);
    wait_fs();
    chk("sim_sw7",  sw, 7);
    chk("sim_pend", duty_pending, 0);
    btn_up = 1'b1; btn_dn = 1'b1;
    ticks(7);  chk("sim_t7", dut.tgt_q, 7);
    ticks(3);
    btn_up = 1'b0; btn_dn = 1'b0;
    ticks(12);
    chk("sim_end", dut.tgt_q, 7);

    // Frame alignment: step edge coincides with a frame_sync edge
    for (int i = 0; i < 3; i++) tap(1'b0);
    wait_fs();
    chk("fa_sw4",  sw, 4);
    chk("fa_tgt4", dut.tgt_q, 4);
    for (int i = 0; i < 8 && ph != 2; i++) tick();
    btn_up = 1'b1;
    ticks(6);
    chk("fa_pre_tgt", dut.tgt_q, 4);
    tick();
    btn_up = 1'b0;
    chk("fa_tgt5",  dut.tgt_q, 5);
    chk("fa_sw_old", sw, 4);
    chk("fa_pend1", duty_pending, 1);
    ticks(7);
    chk("fa_sw_wait", sw, 4);
    chk("fa_pend_wait", duty_pending, 1);
    tick();
    chk("fa_sw5",   sw, 5);
    chk("fa_pend0", duty_pending, 0);

    // Reset mid-hold: 5 -> 6 (press) -> 7 (first repeat), then reset
    ticks(12);
    btn_up = 1'b1;
    ticks(30);
    chk("rh_tgt7", dut.tgt_q, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rh_tgt0", dut.tgt_q, 0);
    chk("rh_sw0",  sw, 0);
    chk("rh_pend", duty_pending, 0);
    ticks(2);
    btn_up = 1'b0;
    ticks(30);
    chk("rh_quiet", dut.tgt_q, 0);
    tap(1'b1);
    chk("rh_repress", dut.tgt_q, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
